// File: rtl/sw_debounce_pkg.sv
// Shared helpers for the switch debouncer: counter sizing used by the top
// level to dimension every per-bit stability counter.
package sw_debounce_pkg;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_if.sv
// Switch bus between the raw board switches and the downstream mask logic.
// The slave side is the debouncer; the master side is whoever drives i_sw.
interface sw_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] i_sw;
  logic [WIDTH-1:0] o_sw;
  logic [WIDTH-1:0] o_changed;
  logic             o_busy;

  modport master (
    output i_sw,
    input  o_sw,
    input  o_changed,
    input  o_busy
  );

  modport slave (
    input  i_sw,
    output o_sw,
    output o_changed,
    output o_busy
  );
endinterface

// File: rtl/sw_debounce_bit.sv
// Single-bit debouncer: two-flop synchroniser, stability counter, and
// registered output/change flops.
module sw_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CW              = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sw,
  output logic o_sw,
  output logic o_changed,
  output logic o_busy
);

  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sw_q, sw_d;
  logic          changed_q, changed_d;

  // Any agreement between the synchronised input and the output restarts the interval.
  always_comb begin
    s1_d      = i_sw;
    s2_d      = s1_q;
    cnt_d     = '0;
    sw_d      = sw_q;
    changed_d = 1'b0;
    if (s2_q != sw_q) begin
      if (cnt_q == LAST) begin
        sw_d      = s2_q;
        changed_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      sw_q      <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cnt_q     <= cnt_d;
      sw_q      <= sw_d;
      changed_q <= changed_d;
    end
  end

  assign o_sw      = sw_q;
  assign o_changed = changed_q;
  assign o_busy    = (cnt_q != '0);

endmodule

// File: rtl/sw_debounce.sv
// Parallel switch debouncer feeding the LED mask bus: WIDTH independent
// per-bit debouncers plus a combined busy flag.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic           i_clk,
  input  logic           i_reset,
  sw_debounce_if.slave   bus
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sw_vec;
  logic [WIDTH-1:0] changed_vec;
  logic [WIDTH-1:0] busy_vec;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CW              (CW)
    ) u_bit (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_sw      (bus.i_sw[i]),
      .o_sw      (sw_vec[i]),
      .o_changed (changed_vec[i]),
      .o_busy    (busy_vec[i])
    );
  end

  assign bus.o_sw      = sw_vec;
  assign bus.o_changed = changed_vec;
  assign bus.o_busy    = |busy_vec;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: a DEBOUNCE_CYCLES=4 instance for the main
// scenarios and a DEBOUNCE_CYCLES=1 instance for the minimum-latency case.
module tb_sw_debounce;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  sw_debounce_if #(.WIDTH(4)) bus ();
  sw_debounce_if #(.WIDTH(4)) bus_min ();

  sw_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus.slave)
  );

  sw_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(1)) dut_min (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus_min.slave)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.i_sw = 4'b0000;
    bus_min.i_sw = 4'b0000;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    logic [3:0] exp_sw, exp_chg;
    logic       exp_busy;
    reset = 1'b1;
    bus.i_sw = 4'b1111;
    bus_min.i_sw = 4'b0000;
    for (int j = 1; j <= 3; j++) begin
      step();
      checks++;
      if (bus.o_sw !== 4'b0000 || bus.o_changed !== 4'b0000 || bus.o_busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_hold j=%0d got sw=%b chg=%b busy=%b exp sw=0000 chg=0000 busy=0",
                 j, bus.o_sw, bus.o_changed, bus.o_busy);
      end
    end
    reset = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      step();
      exp_sw   = (j >= 6) ? 4'b1111 : 4'b0000;
      exp_chg  = (j == 6) ? 4'b1111 : 4'b0000;
      exp_busy = (j >= 3 && j <= 5);
      checks++;
      if (bus.o_sw !== exp_sw || bus.o_changed !== exp_chg || bus.o_busy !== exp_busy) begin
        failures++;
        $display("[TB] FAIL reset_release j=%0d got sw=%b chg=%b busy=%b exp sw=%b chg=%b busy=%b",
                 j, bus.o_sw, bus.o_changed, bus.o_busy, exp_sw, exp_chg, exp_busy);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_sw, exp_chg;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      bus.i_sw = (p % 2 == 0) ? 4'b0001 : 4'b0000;
      for (int j = 0; j < 2; j++) begin
        step();
        checks++;
        if (bus.o_sw !== 4'b0000 || bus.o_changed !== 4'b0000) begin
          failures++;
          $display("[TB] FAIL bounce_glitch p=%0d got sw=%b chg=%b exp sw=0000 chg=0000",
                   p, bus.o_sw, bus.o_changed);
        end
      end
    end
    bus.i_sw = 4'b0001;
    for (int j = 1; j <= 7; j++) begin
      step();
      exp_sw  = (j >= 6) ? 4'b0001 : 4'b0000;
      exp_chg = (j == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (bus.o_sw !== exp_sw || bus.o_changed !== exp_chg) begin
        failures++;
        $display("[TB] FAIL bounce_settle j=%0d got sw=%b chg=%b exp sw=%b chg=%b",
                 j, bus.o_sw, bus.o_changed, exp_sw, exp_chg);
      end
    end
  endtask

  task automatic test_short_pulse();
    logic exp_busy;
    do_reset();
    bus.i_sw = 4'b0100;
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j == 3) bus.i_sw = 4'b0000;
      exp_busy = (j >= 3 && j <= 5);
      checks++;
      if (bus.o_sw !== 4'b0000 || bus.o_changed !== 4'b0000 || bus.o_busy !== exp_busy) begin
        failures++;
        $display("[TB] FAIL short_pulse j=%0d got sw=%b chg=%b busy=%b exp sw=0000 chg=0000 busy=%b",
                 j, bus.o_sw, bus.o_changed, bus.o_busy, exp_busy);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_sw, exp_chg;
    do_reset();
    bus.i_sw = 4'b1010;
    for (int j = 1; j <= 7; j++) begin
      step();
      exp_sw  = (j >= 6) ? 4'b1010 : 4'b0000;
      exp_chg = (j == 6) ? 4'b1010 : 4'b0000;
      checks++;
      if (bus.o_sw !== exp_sw || bus.o_changed !== exp_chg) begin
        failures++;
        $display("[TB] FAIL simultaneous j=%0d got sw=%b chg=%b exp sw=%b chg=%b",
                 j, bus.o_sw, bus.o_changed, exp_sw, exp_chg);
      end
    end
  endtask

  task automatic test_mid_count_reset();
    logic [3:0] exp_sw, exp_chg;
    do_reset();
    bus.i_sw = 4'b0001;
    repeat (4) step();
    checks++;
    if (bus.o_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_busy got=%b exp=1", bus.o_busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (bus.o_sw !== 4'b0000 || bus.o_busy !== 1'b0 || bus.o_changed !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL midreset_clear got sw=%b busy=%b chg=%b exp sw=0000 busy=0 chg=0000",
               bus.o_sw, bus.o_busy, bus.o_changed);
    end
    for (int j = 1; j <= 7; j++) begin
      step();
      exp_sw  = (j >= 6) ? 4'b0001 : 4'b0000;
      exp_chg = (j == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (bus.o_sw !== exp_sw || bus.o_changed !== exp_chg) begin
        failures++;
        $display("[TB] FAIL midreset_relatch j=%0d got sw=%b chg=%b exp sw=%b chg=%b",
                 j, bus.o_sw, bus.o_changed, exp_sw, exp_chg);
      end
    end
  endtask

  task automatic test_all_fall();
    logic [3:0] exp_sw, exp_chg;
    bus.i_sw = 4'b1111;
    repeat (10) step();
    checks++;
    if (bus.o_sw !== 4'b1111 || bus.o_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL steady_high got sw=%b busy=%b exp sw=1111 busy=0", bus.o_sw, bus.o_busy);
    end
    bus.i_sw = 4'b0000;
    for (int j = 1; j <= 7; j++) begin
      step();
      exp_sw  = (j >= 6) ? 4'b0000 : 4'b1111;
      exp_chg = (j == 6) ? 4'b1111 : 4'b0000;
      checks++;
      if (bus.o_sw !== exp_sw || bus.o_changed !== exp_chg) begin
        failures++;
        $display("[TB] FAIL all_fall j=%0d got sw=%b chg=%b exp sw=%b chg=%b",
                 j, bus.o_sw, bus.o_changed, exp_sw, exp_chg);
      end
    end
  endtask

  task automatic test_min_debounce();
    logic [3:0] exp_sw, exp_chg;
    do_reset();
    bus_min.i_sw = 4'b0101;
    for (int j = 1; j <= 4; j++) begin
      step();
      exp_sw  = (j >= 3) ? 4'b0101 : 4'b0000;
      exp_chg = (j == 3) ? 4'b0101 : 4'b0000;
      checks++;
      if (bus_min.o_sw !== exp_sw || bus_min.o_changed !== exp_chg || bus_min.o_busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL min_debounce j=%0d got sw=%b chg=%b busy=%b exp sw=%b chg=%b busy=0",
                 j, bus_min.o_sw, bus_min.o_changed, bus_min.o_busy, exp_sw, exp_chg);
      end
    end
  endtask

  initial begin
    bus.i_sw = 4'b0000;
    bus_min.i_sw = 4'b0000;
    test_reset();
    test_bounce();
    test_short_pulse();
    test_simultaneous();
    test_mid_count_reset();
    test_all_fall();
    test_min_debounce();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
